// File: rtl/quantser_pkg.sv
// ============================================================================
// quantser_pkg : shared state encoding and default sizes for the quantizing
//                bit-plane serializer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package quantser_pkg;

  localparam int QS_N_DEF     = 64;
  localparam int QS_BACC_DEF  = 27;
  localparam int QS_BMSB_DEF  = 5;
  localparam int QS_BPREC_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/quantser_quantlane.sv
// ============================================================================
// quantlane : selects bit (msb - k) of one accumulator lane.
//             Out-of-range msb is clamped to the sign bit; negative index gives 0.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module quantlane import quantser_pkg::*; #(
  parameter int BACC  = QS_BACC_DEF,
  parameter int BMSB  = QS_BMSB_DEF,
  parameter int BPREC = QS_BPREC_DEF
) (
  input  logic [BACC-1:0]  lane_i,
  input  logic [BMSB-1:0]  msb_i,
  input  logic [BPREC-1:0] k_i,
  output logic             bit_o
);

  // Two spare bits so the top bit of the difference acts as a sign flag.
  localparam int IW = ((BMSB > BPREC) ? BMSB : BPREC) + 2;
  localparam logic [IW-1:0] C_TOP = IW'(BACC - 1);

  logic [IW-1:0]   w_msb_ext;
  logic [IW-1:0]   w_msb_clamped;
  logic [IW-1:0]   w_idx;
  logic [BACC-1:0] w_mask;

  always_comb begin
    w_msb_ext     = IW'(msb_i);
    w_msb_clamped = (w_msb_ext > C_TOP) ? C_TOP : w_msb_ext;
    w_idx         = w_msb_clamped - IW'(k_i);
    w_mask        = BACC'(1) << w_idx[IW-2:0];
    bit_o         = ~w_idx[IW-1] & (|(lane_i & w_mask));
  end

endmodule

`default_nettype wire

// File: rtl/quantser.sv
// ============================================================================
// quantser : registers an N-lane accumulator vector and emits it as
//            max(prec,1) bit-planes, MSB first, one plane per step pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module quantser import quantser_pkg::*; #(
  parameter int N     = QS_N_DEF,
  parameter int BACC  = QS_BACC_DEF,
  parameter int BMSB  = QS_BMSB_DEF,
  parameter int BPREC = QS_BPREC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inval,
  output logic              inrdy,
  input  logic [N*BACC-1:0] indata,
  input  logic [BMSB-1:0]   msbidx,
  input  logic [BPREC-1:0]  prec,
  output logic              step,
  output logic [N-1:0]      dataout,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [N*BACC-1:0]  data_q, data_d;
  logic [BMSB-1:0]    msb_q, msb_d;
  logic [BPREC-1:0]   lastk_q, lastk_d;
  logic [BPREC-1:0]   k_q, k_d;
  logic [N-1:0]       dataout_q, dataout_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               inrdy_q, inrdy_d;

  logic               w_xfer;
  logic [N*BACC-1:0]  w_src_data;
  logic [BMSB-1:0]    w_src_msb;
  logic [BPREC-1:0]   w_src_k;
  logic [N-1:0]       w_plane;

  // The lanes evaluate the plane that will be visible next cycle, so the
  // registered dataout lines up with step without an extra pipeline stage.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    quantlane #(
      .BACC  (BACC),
      .BMSB  (BMSB),
      .BPREC (BPREC)
    ) u_lane (
      .lane_i (w_src_data[gi*BACC +: BACC]),
      .msb_i  (w_src_msb),
      .k_i    (w_src_k),
      .bit_o  (w_plane[gi])
    );
  end

  always_comb begin
    w_xfer     = inval & inrdy_q;
    state_d    = state_q;
    data_d     = data_q;
    msb_d      = msb_q;
    lastk_d    = lastk_q;
    k_d        = k_q;
    dataout_d  = dataout_q;
    w_src_data = data_q;
    w_src_msb  = msb_q;
    w_src_k    = k_q + 1'b1;

    if (w_xfer) begin
      state_d    = ST_SHIFT;
      data_d     = indata;
      msb_d      = msbidx;
      lastk_d    = (prec == '0) ? '0 : prec - 1'b1;
      k_d        = '0;
      w_src_data = indata;
      w_src_msb  = msbidx;
      w_src_k    = '0;
      dataout_d  = w_plane;
    end else if (state_q == ST_SHIFT) begin
      if (done_q) begin
        state_d = ST_IDLE;
        k_d     = '0;
      end else begin
        k_d       = k_q + 1'b1;
        dataout_d = w_plane;
      end
    end

    step_d  = (state_d == ST_SHIFT);
    done_d  = step_d && (k_d == lastk_d);
    inrdy_d = !step_d || done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      msb_q     <= '0;
      lastk_q   <= '0;
      k_q       <= '0;
      dataout_q <= '0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      inrdy_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      msb_q     <= msb_d;
      lastk_q   <= lastk_d;
      k_q       <= k_d;
      dataout_q <= dataout_d;
      step_q    <= step_d;
      done_q    <= done_d;
      inrdy_q   <= inrdy_d;
    end
  end

  assign step    = step_q;
  assign busy    = step_q;
  assign done    = done_q;
  assign inrdy   = inrdy_q;
  assign dataout = dataout_q;

endmodule

`default_nettype wire

// File: tb/tb_quantser.sv
// ============================================================================
// tb_quantser : directed self-checking bench for quantser (N=4, BACC=8).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_quantser;

  localparam int N     = 4;
  localparam int BACC  = 8;
  localparam int BMSB  = 5;
  localparam int BPREC = 4;

  localparam logic [N*BACC-1:0] C_VEC_A = {8'h55, 8'h80, 8'h00, 8'h7F};
  localparam logic [N*BACC-1:0] C_VEC_B = {8'h00, 8'h02, 8'hFF, 8'h01};

  logic              clk;
  logic              rst_n;
  logic              inval;
  logic              inrdy;
  logic [N*BACC-1:0] indata;
  logic [BMSB-1:0]   msbidx;
  logic [BPREC-1:0]  prec;
  logic              step;
  logic [N-1:0]      dataout;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;
  int step_cnt = 0;
  int cnt0;

  quantser #(
    .N     (N),
    .BACC  (BACC),
    .BMSB  (BMSB),
    .BPREC (BPREC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inval   (inval),
    .inrdy   (inrdy),
    .indata  (indata),
    .msbidx  (msbidx),
    .prec    (prec),
    .step    (step),
    .dataout (dataout),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step) step_cnt <= step_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N*BACC-1:0] d, input logic [BMSB-1:0] m,
                      input logic [BPREC-1:0] p);
    indata = d;
    msbidx = m;
    prec   = p;
    inval  = 1'b1;
    tick();
    inval  = 1'b0;
  endtask

  task automatic plane(input string tag, input logic [N-1:0] exp, input logic last);
    chk({tag, " step"},    32'(step),    32'd1);
    chk({tag, " busy"},    32'(busy),    32'd1);
    chk({tag, " dataout"}, 32'(dataout), 32'(exp));
    chk({tag, " done"},    32'(done),    32'(last));
    chk({tag, " inrdy"},   32'(inrdy),   32'(last));
    tick();
  endtask

  task automatic idle_chk(input string tag, input logic [N-1:0] hold);
    chk({tag, " idle step"},  32'(step),    32'd0);
    chk({tag, " idle busy"},  32'(busy),    32'd0);
    chk({tag, " idle done"},  32'(done),    32'd0);
    chk({tag, " idle inrdy"}, 32'(inrdy),   32'd1);
    chk({tag, " idle hold"},  32'(dataout), 32'(hold));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    inval  = 1'b0;
    indata = '0;
    msbidx = '0;
    prec   = '0;
    tick();
    tick();
    chk("rst step",    32'(step),    32'd0);
    chk("rst busy",    32'(busy),    32'd0);
    chk("rst done",    32'(done),    32'd0);
    chk("rst dataout", 32'(dataout), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst inrdy",   32'(inrdy),   32'd1);

    // msbidx=7, prec=2: bit7 then bit6
    cnt0 = step_cnt;
    send(C_VEC_A, 5'd7, 4'd2);
    plane("v30 p0", 4'b0100, 1'b0);
    plane("v30 p1", 4'b1001, 1'b1);
    idle_chk("v30", 4'b1001);
    chk("v30 steps", 32'(step_cnt - cnt0), 32'd2);

    // msbidx=1, prec=4: two data planes then two zero planes
    cnt0 = step_cnt;
    send(C_VEC_A, 5'd1, 4'd4);
    plane("v31 p0", 4'b0001, 1'b0);
    plane("v31 p1", 4'b1001, 1'b0);
    plane("v31 p2", 4'b0000, 1'b0);
    plane("v31 p3", 4'b0000, 1'b1);
    idle_chk("v31", 4'b0000);
    chk("v31 steps", 32'(step_cnt - cnt0), 32'd4);

    // prec=0 acts as 1; msbidx=12 clamps to the sign bit
    cnt0 = step_cnt;
    send(C_VEC_A, 5'd12, 4'd0);
    plane("v32 p0", 4'b0100, 1'b1);
    idle_chk("v32", 4'b0100);
    tick();
    chk("v32 steps", 32'(step_cnt - cnt0), 32'd1);

    // back-to-back vectors with inval held high
    cnt0 = step_cnt;
    indata = C_VEC_A;
    msbidx = 5'd7;
    prec   = 4'd3;
    inval  = 1'b1;
    tick();
    indata = C_VEC_B;
    msbidx = 5'd2;
    plane("v33 a0", 4'b0100, 1'b0);
    plane("v33 a1", 4'b1001, 1'b0);
    plane("v33 a2", 4'b0001, 1'b1);
    inval = 1'b0;
    plane("v33 b0", 4'b0010, 1'b0);
    plane("v33 b1", 4'b0110, 1'b0);
    plane("v33 b2", 4'b0011, 1'b1);
    idle_chk("v33", 4'b0011);
    chk("v33 steps", 32'(step_cnt - cnt0), 32'd6);

    // inval toggled in non-last cycles is ignored
    cnt0 = step_cnt;
    send(C_VEC_B, 5'd2, 4'd3);
    indata = C_VEC_A;
    msbidx = 5'd7;
    prec   = 4'd4;
    inval  = 1'b1;
    plane("v35 p0", 4'b0010, 1'b0);
    inval  = 1'b0;
    plane("v35 p1", 4'b0110, 1'b0);
    plane("v35 p2", 4'b0011, 1'b1);
    idle_chk("v35", 4'b0011);
    tick();
    tick();
    chk("v35 steps", 32'(step_cnt - cnt0), 32'd3);

    // reset in the 2nd SHIFT cycle aborts the vector
    send(C_VEC_A, 5'd7, 4'd4);
    plane("v34 p0", 4'b0100, 1'b0);
    chk("v34 p1 step", 32'(step), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("v34 abort step",    32'(step),    32'd0);
    chk("v34 abort busy",    32'(busy),    32'd0);
    chk("v34 abort done",    32'(done),    32'd0);
    chk("v34 abort dataout", 32'(dataout), 32'd0);
    cnt0 = step_cnt;
    tick();
    rst_n = 1'b1;
    chk("v34 inrdy", 32'(inrdy), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("v34 residual steps", 32'(step_cnt - cnt0), 32'd0);
    chk("v34 final step",     32'(step),             32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
